instr_decode_pipe: RTL
======================

# instr_decode_pipe

Parametrised, pipelined successor to the DungV instruction decoder. It sits between the fetch unit and the execute/GPIO/memory units and accepts one instruction word per valid/ready handshake. It emits a registered, fully decoded bundle with an explicit illegal-instruction indication, and supports an optional two-word extended-immediate instruction.

## Interface
- INSTR_W, 32: instruction width. Must be ≥ 30 and ≥ 6+REG_AW+IMM_W.
- REG_AW, 6: register index width.
- IMM_W, 16: short immediate width.
- MEM_AW, 10: memory address width. Must satisfy 4+MEM_AW+IMM_W ≤ INSTR_W.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous; discards output entry and extended-instruction state.
- in_valid  in  1  instruction word present.
- in_ready  out  1  decoder can accept this cycle.
- instr  in  INSTR_W  instruction word.
- out_valid  out  1  decoded bundle present.
- out_ready  in  1  consumer accepts bundle.
- flag  out  2  instruction class.
- oper  out  4  operation code.
- rega, regb  out  REG_AW  register indices.
- imm  out  IMM_W  short immediate.
- mem_op  out  2  memory operation.
- mem_addr  out  MEM_AW  memory address.
- imm_ext  out  INSTR_W  extended immediate; zero unless LDX.
- illegal  out  1  bundle is an illegal instruction.

## Operation
- Fields are counted from the MSB. flag = instr[W-1:W-2], where W = INSTR_W.
- Class 0 (GPIO): oper = next 4 bits; imm = next IMM_W bits.
- Class 1 (ALU reg-reg): oper; rega; regb; imm = 0.
- Class 2:
  - oper = 2: as class 1.
  - oper = 3: rega, then imm from the bits following rega; regb = 0.
  - oper = 4 (LDX): rega. The next accepted word is taken whole as imm_ext.
  - Any other oper: illegal.
- Class 3 (memory): mem_op = 2 bits after flag.
  - mem_op 1/2: rega, then mem_addr; imm = 0.
  - mem_op 0/3: mem_addr, then imm.
- Fields not defined for the decoded form output 0.
- An illegal bundle has illegal = 1, flag and oper as fetched, and all other fields 0.
- Fetch-side state machine:
  - IDLE: normal decode.
  - EXT: waiting for the LDX second word.
  - IDLE → EXT when an LDX first word is accepted. No bundle is produced for that word; rega is held internally.
  - EXT → IDLE when the next word is accepted. That word is never decoded; the bundle carries flag = 2, oper = 4, the held rega, and imm_ext = word.
- flush: out_valid → 0 and state → IDLE on the next edge. Any word handshaken in the same cycle is dropped.

## Timing
- Reset: all outputs 0, state IDLE. in_ready is 1 after reset.
- A single output register stage gives latency = 1 cycle from the accepted handshake to out_valid.
- in_ready = !out_valid || out_ready (combinational). This allows full throughput of 1 word per cycle.
- A bundle is held stable while out_valid && !out_ready.
- An LDX first word is accepted even when out_valid is high, provided in_ready is high. It does not load the output register.
- Simultaneous out_ready and new accept: the register reloads in the same edge, with no bubble.
- rst_n asserted mid-LDX: state returns to IDLE and the held rega is cleared.

## Configuration
- INSTR_DECODE_EXT_IMM_EN defined: LDX and the EXT state are implemented as above.
- Not defined:
  - Class 2 oper 4 decodes as illegal.
  - imm_ext is tied to 0.
  - The state machine is removed; the decoder is stateless apart from the output register.

## Structure
- Package instr_decode_pkg holds:
  - class codes CLS_GPIO / CLS_ALU / CLS_ALU2 / CLS_MEM;
  - oper codes OP_RR = 2, OP_RI = 3, OP_LDX = 4;
  - mem_op codes;
  - the decoded-bundle struct typedef;
  - the state enum.
- One combinational sub-module, instr_field_extract, maps an instruction word to a bundle plus an is_ldx flag. The top level owns the handshake, output register and state machine.

## Test plan
- Reset with default parameters → all outputs 0, in_ready = 1, out_valid = 0.
- instr = 0x54324000, out_ready = 1 → next cycle: flag = 1, oper = 5, rega = 3, regb = 9, imm = 0, illegal = 0.
- instr = 0xD1D55000 → flag = 3, mem_op = 1, rega = 7, mem_addr = 0x155, imm = 0.
- LDX: 0x90200000, then 0xDEADBEEF on consecutive cycles → exactly one bundle with flag = 2, oper = 4, rega = 2, imm_ext = 0xDEADBEEF. Without the macro, the first word gives illegal = 1.
- instr = 0x9C000000 → illegal = 1, flag = 2, oper = 7, all other fields 0.
- Backpressure and flush:
  - Hold out_ready = 0 for 3 cycles with a bundle pending → bundle stable and in_ready = 0.
  - Flush after an LDX first word → state IDLE; the following 0x54324000 decodes normally.

Source files
------------

// File: rtl/instr_decode_pkg.sv
// instr_decode_pkg: shared codes, bundle type and FSM state for instr_decode_pipe.
// No ports; imported by instr_field_extract and instr_decode_pipe.
package instr_decode_pkg;

    // Widths the decoded-bundle struct is built with.
    localparam int ID_INSTR_W = 32;
    localparam int ID_REG_AW  = 6;
    localparam int ID_IMM_W   = 16;
    localparam int ID_MEM_AW  = 10;

    typedef enum logic [1:0] {
        CLS_GPIO = 2'd0,
        CLS_ALU  = 2'd1,
        CLS_ALU2 = 2'd2,
        CLS_MEM  = 2'd3
    } cls_e;

    localparam logic [3:0] OP_RR  = 4'd2;
    localparam logic [3:0] OP_RI  = 4'd3;
    localparam logic [3:0] OP_LDX = 4'd4;

    // Forms 1/2 carry a register plus address; 0/3 carry address plus immediate.
    typedef enum logic [1:0] {
        MOP_IMM_A = 2'd0,
        MOP_REG_A = 2'd1,
        MOP_REG_B = 2'd2,
        MOP_IMM_B = 2'd3
    } mop_e;

    typedef struct packed {
        logic [1:0]            flag;
        logic [3:0]            oper;
        logic [ID_REG_AW-1:0]  rega;
        logic [ID_REG_AW-1:0]  regb;
        logic [ID_IMM_W-1:0]   imm;
        logic [1:0]            mem_op;
        logic [ID_MEM_AW-1:0]  mem_addr;
        logic [ID_INSTR_W-1:0] imm_ext;
        logic                  illegal;
    } bundle_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXT  = 1'b1
    } state_e;

endpackage

// File: rtl/instr_field_extract.sv
// instr_field_extract: combinational map of one instruction word to a decoded bundle.
// Ports: instr (word in), bundle (decoded fields, imm_ext always 0), is_ldx (LDX first word).
// Optional feature macro: INSTR_DECODE_EXT_IMM_EN (without it, class 2 oper 4 is illegal).
module instr_field_extract
    import instr_decode_pkg::*;
#(
    parameter int INSTR_W = ID_INSTR_W,
    parameter int REG_AW  = ID_REG_AW,
    parameter int IMM_W   = ID_IMM_W,
    parameter int MEM_AW  = ID_MEM_AW
) (
    input  logic [INSTR_W-1:0] instr,
    output bundle_t            bundle,
    output logic               is_ldx
);

    localparam int W = INSTR_W;

    cls_e       cls;
    logic [3:0] op;
    logic [1:0] mop;

    // Fields are counted from the MSB; the low bits depend on the form.
    assign cls = cls_e'(instr[W-1 -: 2]);
    assign op  = instr[W-3 -: 4];
    assign mop = instr[W-3 -: 2];

    // Not every form consumes every bit of the word.
    logic unused_instr;
    assign unused_instr = ^instr;

    always_comb begin
        bundle      = '0;
        is_ldx      = 1'b0;
        bundle.flag = cls;
        unique case (cls)
            CLS_GPIO: begin
                bundle.oper = op;
                bundle.imm  = instr[W-7 -: IMM_W];
            end
            CLS_ALU: begin
                bundle.oper = op;
                bundle.rega = instr[W-7 -: REG_AW];
                bundle.regb = instr[W-7-REG_AW -: REG_AW];
            end
            CLS_ALU2: begin
                bundle.oper = op;
                if (op == OP_RR) begin
                    bundle.rega = instr[W-7 -: REG_AW];
                    bundle.regb = instr[W-7-REG_AW -: REG_AW];
                end else if (op == OP_RI) begin
                    bundle.rega = instr[W-7 -: REG_AW];
                    bundle.imm  = instr[W-7-REG_AW -: IMM_W];
`ifdef INSTR_DECODE_EXT_IMM_EN
                end else if (op == OP_LDX) begin
                    bundle.rega = instr[W-7 -: REG_AW];
                    is_ldx      = 1'b1;
`endif
                end else begin
                    bundle.illegal = 1'b1;
                end
            end
            CLS_MEM: begin
                bundle.mem_op = mop;
                if (mop == MOP_REG_A || mop == MOP_REG_B) begin
                    bundle.rega     = instr[W-5 -: REG_AW];
                    bundle.mem_addr = instr[W-5-REG_AW -: MEM_AW];
                end else begin
                    bundle.mem_addr = instr[W-5 -: MEM_AW];
                    bundle.imm      = instr[W-5-MEM_AW -: IMM_W];
                end
            end
        endcase
    end

endmodule

// File: rtl/instr_decode_pipe.sv
// instr_decode_pipe: valid/ready instruction decoder with one registered output stage.
// Ports: clk, rst_n, flush; in_valid/in_ready/instr; out_valid/out_ready; decoded fields.
// Optional feature macro: INSTR_DECODE_EXT_IMM_EN enables two-word LDX (EXT state).
module instr_decode_pipe
    import instr_decode_pkg::*;
#(
    parameter int INSTR_W = ID_INSTR_W,
    parameter int REG_AW  = ID_REG_AW,
    parameter int IMM_W   = ID_IMM_W,
    parameter int MEM_AW  = ID_MEM_AW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [1:0]         flag,
    output logic [3:0]         oper,
    output logic [REG_AW-1:0]  rega,
    output logic [REG_AW-1:0]  regb,
    output logic [IMM_W-1:0]   imm,
    output logic [1:0]         mem_op,
    output logic [MEM_AW-1:0]  mem_addr,
    output logic [INSTR_W-1:0] imm_ext,
    output logic               illegal
);

    // The shared bundle struct fixes the field widths, so instances must match it.
    if (INSTR_W != ID_INSTR_W || REG_AW != ID_REG_AW ||
        IMM_W != ID_IMM_W || MEM_AW != ID_MEM_AW) begin : g_width_check
        $error("instr_decode_pipe widths must match instr_decode_pkg");
    end

    bundle_t dec;
    bundle_t bundle_d, bundle_q;
    logic    out_valid_d, out_valid_q;
    logic    is_ldx;
    logic    accept;
    logic    ext_word;
    logic    ldx_first;

    instr_field_extract #(
        .INSTR_W (INSTR_W),
        .REG_AW  (REG_AW),
        .IMM_W   (IMM_W),
        .MEM_AW  (MEM_AW)
    ) u_extract (
        .instr  (instr),
        .bundle (dec),
        .is_ldx (is_ldx)
    );

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

`ifdef INSTR_DECODE_EXT_IMM_EN
    state_e            state_q, state_d;
    logic [REG_AW-1:0] rega_hold_q, rega_hold_d;
    bundle_t           ext_bundle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rega_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            rega_hold_q <= rega_hold_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else if (accept) begin
            unique case (state_q)
                ST_IDLE: if (is_ldx) state_d = ST_EXT;
                ST_EXT:  state_d = ST_IDLE;
            endcase
        end
    end

    assign ext_word  = (state_q == ST_EXT);
    assign ldx_first = !ext_word && is_ldx;

    always_comb begin
        rega_hold_d = rega_hold_q;
        if (flush || (accept && ext_word)) begin
            rega_hold_d = '0;
        end else if (accept && ldx_first) begin
            rega_hold_d = dec.rega;
        end
    end

    // The second LDX word is never decoded; it is carried whole.
    always_comb begin
        ext_bundle         = '0;
        ext_bundle.flag    = CLS_ALU2;
        ext_bundle.oper    = OP_LDX;
        ext_bundle.rega    = rega_hold_q;
        ext_bundle.imm_ext = instr;
    end
`else
    logic unused_is_ldx;
    assign unused_is_ldx = is_ldx;
    assign ext_word      = 1'b0;
    assign ldx_first     = 1'b0;
`endif

    // An LDX first word is swallowed: it neither loads nor drains the register.
    always_comb begin
        bundle_d    = bundle_q;
        out_valid_d = out_valid_q && !out_ready;
        if (flush) begin
            bundle_d    = '0;
            out_valid_d = 1'b0;
`ifdef INSTR_DECODE_EXT_IMM_EN
        end else if (accept && ext_word) begin
            bundle_d    = ext_bundle;
            out_valid_d = 1'b1;
`endif
        end else if (accept && !ldx_first) begin
            bundle_d    = dec;
            out_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bundle_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            bundle_q    <= bundle_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign flag      = bundle_q.flag;
    assign oper      = bundle_q.oper;
    assign rega      = bundle_q.rega;
    assign regb      = bundle_q.regb;
    assign imm       = bundle_q.imm;
    assign mem_op    = bundle_q.mem_op;
    assign mem_addr  = bundle_q.mem_addr;
    assign imm_ext   = bundle_q.imm_ext;
    assign illegal   = bundle_q.illegal;

endmodule
